aes_state_loader: RTL

Input staging stage for the AES datapath. It accepts the 128-bit plaintext block as four 32-bit words over a valid/ready stream and assembles them into a full block. It presents the block on `state` with a valid/ready handshake to the AES core and to the trigger logic, which compares `state` combinationally. It double-buffers, so assembly of the next block overlaps consumption of the current one.

---
 rtl/aes_tj_pkg.sv | 13 +
 rtl/aes_ldr_timeout.sv | 25 ++
 rtl/aes_state_loader.sv | 106 ++++++++++
 3 files changed

// File: rtl/aes_tj_pkg.sv
// rtl/aes_tj_pkg.sv - shared AES datapath widths and loader FSM encoding
package aes_tj_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_WORD_W = 32;
  localparam int AES_WORDS  = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } ldr_state_e;

endpackage

// File: rtl/aes_ldr_timeout.sv
// rtl/aes_ldr_timeout.sv - idle-cycle counter that fires once every TERM enabled cycles
module aes_ldr_timeout #(
  parameter int TERM = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [7:0] r_cnt;

  // Fires on the TERM-th consecutive enabled cycle, then starts over.
  assign expire = en && !clr && (r_cnt == 8'(TERM - 1));

  always_ff @(posedge clk) begin
    if (rst || clr || expire) begin
      r_cnt <= 8'd0;
    end else if (en) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/aes_state_loader.sv
// rtl/aes_state_loader.sv - double-buffered 4x32 -> 128-bit block stager for the AES core
// Optional partial-block timeout: define AES_LDR_TIMEOUT_EN.
module aes_state_loader
  import aes_tj_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AES_WORD_W-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [AES_BLK_W-1:0]  state,
  output logic                  state_valid,
  input  logic                  state_ready,
  output logic                  busy,
  output logic                  abort
);

  ldr_state_e           r_fsm;
  logic [AES_BLK_W-1:0] r_buf;
  logic [AES_BLK_W-1:0] r_state;
  logic [2:0]           r_wcnt;
  logic                 r_state_valid;

  logic                 w_accept;
  logic                 w_slot_free;
  logic                 w_fill_done;
  logic                 w_load;
  logic                 w_expire;
  logic [AES_BLK_W-1:0] w_next_buf;

  assign din_ready   = !rst && (r_fsm == FILL);
  assign w_accept    = din_valid && din_ready;
  assign w_slot_free = !r_state_valid || state_ready;
  assign w_next_buf  = {r_buf[AES_BLK_W-AES_WORD_W-1:0], din};
  assign w_fill_done = (r_fsm == FILL) && w_accept && (r_wcnt == 3'(AES_WORDS - 1));
  assign w_load      = (w_fill_done || (r_fsm == HOLD)) && w_slot_free;

`ifdef AES_LDR_TIMEOUT_EN
  logic w_idle_en;
  logic w_idle_clr;
  logic r_abort;

  assign w_idle_en  = (r_fsm == FILL) && (r_wcnt != 3'd0) && !w_accept;
  assign w_idle_clr = w_accept || (r_wcnt == 3'd0);

  aes_ldr_timeout #(
    .TERM (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_idle_clr),
    .en     (w_idle_en),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_abort <= 1'b0;
    end else begin
      r_abort <= w_expire;
    end
  end

  assign abort = r_abort;
`else
  assign w_expire = 1'b0;
  // TIMEOUT_CYC only matters in the timeout build; this term is constant 0.
  assign abort    = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm         <= FILL;
      r_buf         <= '0;
      r_state       <= '0;
      r_wcnt        <= 3'd0;
      r_state_valid <= 1'b0;
    end else if (w_load) begin
      // A completed block replaces state; a concurrent transfer-out keeps valid high.
      r_state       <= (r_fsm == HOLD) ? r_buf : w_next_buf;
      r_state_valid <= 1'b1;
      r_wcnt        <= 3'd0;
      r_fsm         <= FILL;
    end else begin
      if (r_state_valid && state_ready) begin
        r_state_valid <= 1'b0;
      end
      if (w_accept) begin
        r_buf  <= w_next_buf;
        r_wcnt <= r_wcnt + 3'd1;
        if (r_wcnt == 3'(AES_WORDS - 1)) begin
          r_fsm <= HOLD;
        end
      end else if (w_expire) begin
        r_wcnt <= 3'd0;
      end
    end
  end

  assign state       = r_state;
  assign state_valid = r_state_valid;
  assign busy        = (r_wcnt != 3'd0);

endmodule
